// File: rtl/imem_arbiter.sv
// Memory-bus arbiter for dcache, icache and prefetcher with a tag table that
// routes returned load data back to the requester that issued it.
module imem_arbiter #(
    parameter int unsigned NUM_MEM_TAGS         = 15,
    parameter int unsigned MAX_PREF_OUTSTANDING = 4,
    parameter int unsigned STARVE_LIMIT         = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  dc_cmd,
    input  logic [31:0] dc_addr,
    input  logic [63:0] dc_data,
    input  logic        ic_valid,
    input  logic [31:0] ic_addr,
    input  logic        pf_valid,
    input  logic [31:0] pf_addr,
    input  logic        pf_squash,
    output logic [1:0]  proc2mem_command,
    output logic [31:0] proc2mem_addr,
    output logic [63:0] proc2mem_data,
    input  logic [3:0]  mem2proc_response,
    input  logic [3:0]  mem2proc_tag,
    input  logic [63:0] mem2proc_data,
    output logic        dc_grant,
    output logic        ic_grant,
    output logic        pf_grant,
    output logic        dc_rsp_valid,
    output logic        ic_rsp_valid,
    output logic        pf_rsp_valid,
    output logic [31:0] rsp_addr,
    output logic [63:0] rsp_data,
    output logic [2:0]  pf_outstanding
);

    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;

    localparam logic [1:0] OWN_DC = 2'd0;
    localparam logic [1:0] OWN_IC = 2'd1;
    localparam logic [1:0] OWN_PF = 2'd2;

    localparam int unsigned IW = $clog2(NUM_MEM_TAGS + 1);
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [2:0]    PF_MAX     = 3'(MAX_PREF_OUTSTANDING);

    logic        valid_q [1:NUM_MEM_TAGS];
    logic        valid_d [1:NUM_MEM_TAGS];
    logic        drop_q  [1:NUM_MEM_TAGS];
    logic        drop_d  [1:NUM_MEM_TAGS];
    logic [1:0]  owner_q [1:NUM_MEM_TAGS];
    logic [1:0]  owner_d [1:NUM_MEM_TAGS];
    logic [31:0] addr_q  [1:NUM_MEM_TAGS];
    logic [31:0] addr_d  [1:NUM_MEM_TAGS];

    logic [SW-1:0] starve_q, starve_d;
    logic [2:0]    pf_out_q, pf_out_d;
    logic [4:0]    pf_cnt;

    logic        pf_live_hit, pf_eligible, ic_force;
    logic        sel_dc, sel_ic, sel_pf, accept, grant_load;
    logic [1:0]  grant_owner;
    logic        ret_live;
    logic [1:0]  ret_owner;
    logic [31:0] ret_addr;

    always_comb begin
        pf_live_hit = 1'b0;
        for (int unsigned i = 1; i <= NUM_MEM_TAGS; i++) begin
            if (valid_q[IW'(i)] && !drop_q[IW'(i)] && addr_q[IW'(i)] == pf_addr)
                pf_live_hit = 1'b1;
        end
    end

    assign pf_eligible = pf_valid && !pf_squash && (pf_out_q < PF_MAX) && !pf_live_hit;
    assign ic_force    = ic_valid && (starve_q == STARVE_MAX);

    always_comb begin
        sel_dc = 1'b0;
        sel_ic = 1'b0;
        sel_pf = 1'b0;
        if (!reset) begin
            if (ic_force)                 sel_ic = 1'b1;
            else if (dc_cmd != BUS_NONE)  sel_dc = 1'b1;
            else if (ic_valid)            sel_ic = 1'b1;
            else if (pf_eligible)         sel_pf = 1'b1;
        end
    end

    always_comb begin
        proc2mem_command = BUS_NONE;
        proc2mem_addr    = '0;
        proc2mem_data    = '0;
        grant_owner      = OWN_DC;
        if (sel_dc) begin
            proc2mem_command = dc_cmd;
            proc2mem_addr    = dc_addr;
            proc2mem_data    = dc_data;
        end else if (sel_ic) begin
            proc2mem_command = BUS_LOAD;
            proc2mem_addr    = ic_addr;
            grant_owner      = OWN_IC;
        end else if (sel_pf) begin
            proc2mem_command = BUS_LOAD;
            proc2mem_addr    = pf_addr;
            grant_owner      = OWN_PF;
        end
    end

    assign accept     = (mem2proc_response != 4'd0);
    assign dc_grant   = sel_dc && accept;
    assign ic_grant   = sel_ic && accept;
    assign pf_grant   = sel_pf && accept;
    assign grant_load = (dc_grant && dc_cmd == BUS_LOAD) || ic_grant || pf_grant;

    always_comb begin
        ret_live  = 1'b0;
        ret_owner = OWN_DC;
        ret_addr  = '0;
        for (int unsigned i = 1; i <= NUM_MEM_TAGS; i++) begin
            if (mem2proc_tag == 4'(i) && valid_q[IW'(i)] && !drop_q[IW'(i)]) begin
                ret_live  = 1'b1;
                ret_owner = owner_q[IW'(i)];
                ret_addr  = addr_q[IW'(i)];
            end
        end
    end

    always_comb begin
        dc_rsp_valid = 1'b0;
        ic_rsp_valid = 1'b0;
        pf_rsp_valid = 1'b0;
        rsp_addr     = '0;
        rsp_data     = '0;
        if (!reset && ret_live) begin
            case (ret_owner)
                OWN_DC:  dc_rsp_valid = 1'b1;
                OWN_IC:  ic_rsp_valid = 1'b1;
                default: pf_rsp_valid = 1'b1;
            endcase
            rsp_addr = ret_addr;
            rsp_data = mem2proc_data;
        end
    end

    // Return clears first, squash marks survivors, a new accept on the same tag overwrites last.
    always_comb begin
        valid_d = valid_q;
        drop_d  = drop_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        for (int unsigned i = 1; i <= NUM_MEM_TAGS; i++) begin
            if (mem2proc_tag == 4'(i)) begin
                valid_d[IW'(i)] = 1'b0;
                drop_d[IW'(i)]  = 1'b0;
            end
            if (pf_squash && valid_d[IW'(i)] && owner_q[IW'(i)] == OWN_PF)
                drop_d[IW'(i)] = 1'b1;
            if (grant_load && mem2proc_response == 4'(i)) begin
                valid_d[IW'(i)] = 1'b1;
                drop_d[IW'(i)]  = 1'b0;
                owner_d[IW'(i)] = grant_owner;
                addr_d[IW'(i)]  = proc2mem_addr;
            end
        end
    end

    always_comb begin
        pf_cnt = '0;
        for (int unsigned i = 1; i <= NUM_MEM_TAGS; i++) begin
            if (valid_d[IW'(i)] && !drop_d[IW'(i)] && owner_d[IW'(i)] == OWN_PF)
                pf_cnt = pf_cnt + 5'd1;
        end
        pf_out_d = (pf_cnt >= 5'(MAX_PREF_OUTSTANDING)) ? PF_MAX : pf_cnt[2:0];
    end

    always_comb begin
        starve_d = starve_q;
        if (ic_grant)
            starve_d = '0;
        else if (ic_valid && starve_q != STARVE_MAX)
            starve_d = starve_q + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q  <= '{default: 1'b0};
            drop_q   <= '{default: 1'b0};
            starve_q <= '0;
            pf_out_q <= '0;
        end else begin
            valid_q  <= valid_d;
            drop_q   <= drop_d;
            starve_q <= starve_d;
            pf_out_q <= pf_out_d;
        end
    end

    // Payload fields are only meaningful while valid, so they carry no reset.
    always_ff @(posedge clock) begin
        owner_q <= owner_d;
        addr_q  <= addr_d;
    end

    assign pf_outstanding = pf_out_q;

    logic unused_store_enc;
    assign unused_store_enc = (BUS_STORE == 2'd2);

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: directed scenarios plus a randomized
// run compared against a table-level reference model.
module tb_imem_arbiter;

    localparam int N    = 15;
    localparam int MAXP = 4;
    localparam int LIM  = 4;

    localparam logic [1:0] NONE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] STORE = 2'd2;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  dc_cmd;
    logic [31:0] dc_addr;
    logic [63:0] dc_data;
    logic        ic_valid;
    logic [31:0] ic_addr;
    logic        pf_valid;
    logic [31:0] pf_addr;
    logic        pf_squash;
    logic [1:0]  proc2mem_command;
    logic [31:0] proc2mem_addr;
    logic [63:0] proc2mem_data;
    logic [3:0]  mem2proc_response;
    logic [3:0]  mem2proc_tag;
    logic [63:0] mem2proc_data;
    logic        dc_grant, ic_grant, pf_grant;
    logic        dc_rsp_valid, ic_rsp_valid, pf_rsp_valid;
    logic [31:0] rsp_addr;
    logic [63:0] rsp_data;
    logic [2:0]  pf_outstanding;

    int checks   = 0;
    int failures = 0;

    imem_arbiter #(
        .NUM_MEM_TAGS(N),
        .MAX_PREF_OUTSTANDING(MAXP),
        .STARVE_LIMIT(LIM)
    ) dut (
        .clock(clock), .reset(reset),
        .dc_cmd(dc_cmd), .dc_addr(dc_addr), .dc_data(dc_data),
        .ic_valid(ic_valid), .ic_addr(ic_addr),
        .pf_valid(pf_valid), .pf_addr(pf_addr), .pf_squash(pf_squash),
        .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
        .proc2mem_data(proc2mem_data),
        .mem2proc_response(mem2proc_response), .mem2proc_tag(mem2proc_tag),
        .mem2proc_data(mem2proc_data),
        .dc_grant(dc_grant), .ic_grant(ic_grant), .pf_grant(pf_grant),
        .dc_rsp_valid(dc_rsp_valid), .ic_rsp_valid(ic_rsp_valid),
        .pf_rsp_valid(pf_rsp_valid),
        .rsp_addr(rsp_addr), .rsp_data(rsp_data),
        .pf_outstanding(pf_outstanding)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs;
        dc_cmd = NONE; dc_addr = '0; dc_data = '0;
        ic_valid = 1'b0; ic_addr = '0;
        pf_valid = 1'b0; pf_addr = '0; pf_squash = 1'b0;
        mem2proc_response = '0; mem2proc_tag = '0; mem2proc_data = '0;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        @(negedge clock);
        checks++;
        if ({proc2mem_command, dc_grant, ic_grant, pf_grant, dc_rsp_valid, ic_rsp_valid, pf_rsp_valid, pf_outstanding} !== '0) begin
            failures++;
            $display("FAIL reset_idle got cmd=%0d g=%b%b%b r=%b%b%b pfo=%0d want all 0", proc2mem_command,
                     dc_grant, ic_grant, pf_grant, dc_rsp_valid, ic_rsp_valid, pf_rsp_valid, pf_outstanding);
        end
        dc_cmd = LOAD; dc_addr = 32'h100; mem2proc_response = 4'd3;
        tick();
        reset = 1'b1; mem2proc_tag = 4'd3; mem2proc_data = 64'h1234;
        @(negedge clock);
        checks++;
        if ({proc2mem_command, dc_grant, ic_grant, pf_grant, dc_rsp_valid, ic_rsp_valid, pf_rsp_valid} !== '0
            || rsp_addr !== '0 || rsp_data !== '0) begin
            failures++;
            $display("FAIL reset_outputs got cmd=%0d g=%b%b%b r=%b%b%b addr=%h data=%h want all 0", proc2mem_command,
                     dc_grant, ic_grant, pf_grant, dc_rsp_valid, ic_rsp_valid, pf_rsp_valid, rsp_addr, rsp_data);
        end
        tick();
        reset = 1'b0;
        idle_inputs();
        mem2proc_tag = 4'd3; mem2proc_data = 64'h5678;
        @(negedge clock);
        checks++;
        if ({dc_rsp_valid, ic_rsp_valid, pf_rsp_valid} !== 3'b000) begin
            failures++;
            $display("FAIL reset_discard got rsp=%b%b%b want 000", dc_rsp_valid, ic_rsp_valid, pf_rsp_valid);
        end
        tick();
    endtask

    task automatic test_dc_priority;
        do_reset();
        dc_cmd = LOAD; dc_addr = 32'h100; ic_valid = 1'b1; ic_addr = 32'h200; mem2proc_response = 4'd3;
        @(negedge clock);
        checks++;
        if ({dc_grant, ic_grant, pf_grant} !== 3'b100 || proc2mem_command !== LOAD || proc2mem_addr !== 32'h100) begin
            failures++;
            $display("FAIL dc_priority got g=%b%b%b cmd=%0d addr=%h want 100 cmd=1 addr=100",
                     dc_grant, ic_grant, pf_grant, proc2mem_command, proc2mem_addr);
        end
        tick();
        idle_inputs();
        mem2proc_tag = 4'd3; mem2proc_data = 64'hCAFE_F00D_0000_0001;
        @(negedge clock);
        checks++;
        if ({dc_rsp_valid, ic_rsp_valid, pf_rsp_valid} !== 3'b100 || rsp_addr !== 32'h100
            || rsp_data !== 64'hCAFE_F00D_0000_0001) begin
            failures++;
            $display("FAIL dc_return got r=%b%b%b addr=%h data=%h want 100 addr=100 data=cafef00d00000001",
                     dc_rsp_valid, ic_rsp_valid, pf_rsp_valid, rsp_addr, rsp_data);
        end
        tick();
        // the entry must be gone, and a store must not allocate one
        dc_cmd = STORE; dc_addr = 32'h180; dc_data = 64'h77; mem2proc_response = 4'd6;
        @(negedge clock);
        checks++;
        if ({dc_rsp_valid, ic_rsp_valid, pf_rsp_valid} !== 3'b000 || dc_grant !== 1'b1 || proc2mem_data !== 64'h77
            || proc2mem_command !== STORE) begin
            failures++;
            $display("FAIL dc_store got r=%b%b%b g=%b cmd=%0d data=%h want r=000 g=1 cmd=2 data=77",
                     dc_rsp_valid, ic_rsp_valid, pf_rsp_valid, dc_grant, proc2mem_command, proc2mem_data);
        end
        tick();
        idle_inputs();
        mem2proc_tag = 4'd6;
        @(negedge clock);
        checks++;
        if ({dc_rsp_valid, ic_rsp_valid, pf_rsp_valid} !== 3'b000) begin
            failures++;
            $display("FAIL store_no_entry got r=%b%b%b want 000", dc_rsp_valid, ic_rsp_valid, pf_rsp_valid);
        end
        tick();
    endtask

    task automatic test_starvation;
        logic [2:0] want;
        do_reset();
        for (int c = 1; c <= 6; c++) begin
            dc_cmd = LOAD; dc_addr = 32'h1000 + 32'(c) * 32'h40;
            ic_valid = (c <= 5); ic_addr = 32'h200;
            mem2proc_response = 4'(c);
            want = (c == 5) ? 3'b010 : 3'b100;
            @(negedge clock);
            checks++;
            if ({dc_grant, ic_grant, pf_grant} !== want) begin
                failures++;
                $display("FAIL starve_cycle%0d got g=%b%b%b want %b", c, dc_grant, ic_grant, pf_grant, want);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_pf_limit;
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            pf_valid = 1'b1; pf_addr = 32'h2000 + 32'(k) * 32'h40; mem2proc_response = 4'(k);
            @(negedge clock);
            checks++;
            if (pf_grant !== 1'b1 || proc2mem_addr !== pf_addr || pf_outstanding !== 3'(k - 1)) begin
                failures++;
                $display("FAIL pf_issue%0d got g=%b addr=%h pfo=%0d want g=1 addr=%h pfo=%0d",
                         k, pf_grant, proc2mem_addr, pf_outstanding, pf_addr, k - 1);
            end
            tick();
        end
        pf_addr = 32'h2140; mem2proc_response = 4'd5;
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            checks++;
            if (pf_outstanding !== 3'd4 || pf_grant !== 1'b0 || proc2mem_command !== NONE) begin
                failures++;
                $display("FAIL pf_full got pfo=%0d g=%b cmd=%0d want pfo=4 g=0 cmd=0",
                         pf_outstanding, pf_grant, proc2mem_command);
            end
            tick();
        end
        mem2proc_tag = 4'd1; mem2proc_data = 64'hABCD;
        @(negedge clock);
        checks++;
        if (pf_rsp_valid !== 1'b1 || rsp_addr !== 32'h2040 || rsp_data !== 64'hABCD || pf_grant !== 1'b0) begin
            failures++;
            $display("FAIL pf_return got r=%b addr=%h data=%h g=%b want r=1 addr=2040 data=abcd g=0",
                     pf_rsp_valid, rsp_addr, rsp_data, pf_grant);
        end
        tick();
        mem2proc_tag = 4'd0; pf_addr = 32'h2080; mem2proc_response = 4'd6;
        @(negedge clock);
        checks++;
        if (pf_outstanding !== 3'd3 || pf_grant !== 1'b0) begin
            failures++;
            $display("FAIL pf_dup_addr got pfo=%0d g=%b want pfo=3 g=0", pf_outstanding, pf_grant);
        end
        tick();
        pf_addr = 32'h2180;
        @(negedge clock);
        checks++;
        if (pf_grant !== 1'b1) begin
            failures++;
            $display("FAIL pf_reissue got g=%b want 1", pf_grant);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_squash;
        do_reset();
        for (int k = 1; k <= 2; k++) begin
            pf_valid = 1'b1; pf_addr = 32'h3000 + 32'(k) * 32'h40; mem2proc_response = 4'(k);
            tick();
        end
        pf_squash = 1'b1; pf_addr = 32'h3100; mem2proc_response = 4'd3;
        @(negedge clock);
        checks++;
        if (pf_outstanding !== 3'd2 || pf_grant !== 1'b0) begin
            failures++;
            $display("FAIL squash_cycle got pfo=%0d g=%b want pfo=2 g=0", pf_outstanding, pf_grant);
        end
        tick();
        idle_inputs();
        for (int k = 1; k <= 2; k++) begin
            mem2proc_tag = 4'(k); mem2proc_data = 64'(k);
            @(negedge clock);
            checks++;
            if (pf_outstanding !== 3'd0 || {dc_rsp_valid, ic_rsp_valid, pf_rsp_valid} !== 3'b000) begin
                failures++;
                $display("FAIL squash_return%0d got pfo=%0d r=%b%b%b want pfo=0 r=000",
                         k, pf_outstanding, dc_rsp_valid, ic_rsp_valid, pf_rsp_valid);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_retry;
        do_reset();
        ic_valid = 1'b1; ic_addr = 32'h300;
        for (int c = 1; c <= 4; c++) begin
            mem2proc_response = (c == 4) ? 4'd7 : 4'd0;
            @(negedge clock);
            checks++;
            if (ic_grant !== (c == 4) || proc2mem_command !== LOAD || proc2mem_addr !== 32'h300) begin
                failures++;
                $display("FAIL retry_cycle%0d got g=%b cmd=%0d addr=%h want g=%0d cmd=1 addr=300",
                         c, ic_grant, proc2mem_command, proc2mem_addr, (c == 4));
            end
            tick();
        end
        idle_inputs();
        mem2proc_tag = 4'd7; mem2proc_data = 64'h99;
        @(negedge clock);
        checks++;
        if (ic_rsp_valid !== 1'b1 || rsp_addr !== 32'h300) begin
            failures++;
            $display("FAIL retry_entry7 got r=%b addr=%h want r=1 addr=300", ic_rsp_valid, rsp_addr);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_same_tag;
        do_reset();
        ic_valid = 1'b1; ic_addr = 32'h40; mem2proc_response = 4'd5;
        tick();
        idle_inputs();
        dc_cmd = LOAD; dc_addr = 32'h500; mem2proc_response = 4'd5;
        mem2proc_tag = 4'd5; mem2proc_data = 64'h4444;
        @(negedge clock);
        checks++;
        if ({dc_rsp_valid, ic_rsp_valid, pf_rsp_valid} !== 3'b010 || rsp_addr !== 32'h40 || dc_grant !== 1'b1) begin
            failures++;
            $display("FAIL same_tag_old got r=%b%b%b addr=%h g=%b want r=010 addr=40 g=1",
                     dc_rsp_valid, ic_rsp_valid, pf_rsp_valid, rsp_addr, dc_grant);
        end
        tick();
        idle_inputs();
        mem2proc_tag = 4'd5;
        @(negedge clock);
        checks++;
        if ({dc_rsp_valid, ic_rsp_valid, pf_rsp_valid} !== 3'b100 || rsp_addr !== 32'h500) begin
            failures++;
            $display("FAIL same_tag_new got r=%b%b%b addr=%h want r=100 addr=500",
                     dc_rsp_valid, ic_rsp_valid, pf_rsp_valid, rsp_addr);
        end
        tick();
        idle_inputs();
    endtask

    // Reference model: tag table as plain arrays, owner 0=dcache 1=icache 2=prefetch.
    bit          m_valid [16];
    bit          m_drop  [16];
    int          m_owner [16];
    logic [31:0] m_addr  [16];
    int          m_starve;

    task automatic test_random;
        bit dc_hold, ic_hold;
        int live, pfo, who, r;
        bit dup, pf_ok, acc;
        logic [1:0]  e_cmd;
        logic [31:0] e_addr;
        logic [63:0] e_data;
        logic [2:0]  e_grant, e_rsp;
        logic [31:0] e_raddr;
        do_reset();
        for (int t = 0; t < 16; t++) begin
            m_valid[t] = 0; m_drop[t] = 0; m_owner[t] = 0; m_addr[t] = '0;
        end
        m_starve = 0;
        dc_hold = 0; ic_hold = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (!dc_hold) begin
                r = $urandom_range(0, 9);
                dc_cmd  = (r < 5) ? NONE : (r < 8) ? LOAD : STORE;
                dc_addr = $urandom;
                dc_data = {$urandom, $urandom};
            end
            if (!ic_hold) begin
                ic_valid = ($urandom_range(0, 2) == 0);
                ic_addr  = $urandom;
            end
            pf_valid  = $urandom_range(0, 1);
            pf_addr   = 32'h8000 + 32'($urandom_range(0, 7)) * 32'h40;
            pf_squash = ($urandom_range(0, 15) == 0);
            mem2proc_response = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            mem2proc_tag      = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            mem2proc_data     = {$urandom, $urandom};

            live = 0; dup = 0;
            for (int t = 1; t <= N; t++) begin
                if (m_valid[t] && !m_drop[t] && m_owner[t] == 2) live++;
                if (m_valid[t] && !m_drop[t] && m_addr[t] == pf_addr) dup = 1;
            end
            pfo   = (live > MAXP) ? MAXP : live;
            pf_ok = pf_valid && !pf_squash && pfo < MAXP && !dup;
            if (ic_valid && m_starve >= LIM) who = 2;
            else if (dc_cmd != NONE)         who = 1;
            else if (ic_valid)               who = 2;
            else if (pf_ok)                  who = 3;
            else                             who = 0;
            e_cmd = NONE; e_addr = '0; e_data = '0;
            if (who == 1) begin e_cmd = dc_cmd; e_addr = dc_addr; e_data = dc_data; end
            if (who == 2) begin e_cmd = LOAD; e_addr = ic_addr; end
            if (who == 3) begin e_cmd = LOAD; e_addr = pf_addr; end
            acc = (mem2proc_response != 0);
            e_grant = (acc && who != 0) ? (3'b100 >> (who - 1)) : 3'b000;
            e_rsp = 3'b000; e_raddr = '0;
            if (mem2proc_tag != 0 && m_valid[mem2proc_tag] && !m_drop[mem2proc_tag]) begin
                e_rsp   = 3'b100 >> m_owner[mem2proc_tag];
                e_raddr = m_addr[mem2proc_tag];
            end

            @(negedge clock);
            checks++;
            if ({proc2mem_command, proc2mem_addr, proc2mem_data} !== {e_cmd, e_addr, e_data}) begin
                failures++;
                $display("FAIL rnd_bus cyc=%0d got cmd=%0d addr=%h data=%h want cmd=%0d addr=%h data=%h",
                         cyc, proc2mem_command, proc2mem_addr, proc2mem_data, e_cmd, e_addr, e_data);
            end
            checks++;
            if ({dc_grant, ic_grant, pf_grant} !== e_grant) begin
                failures++;
                $display("FAIL rnd_grant cyc=%0d got %b%b%b want %b", cyc, dc_grant, ic_grant, pf_grant, e_grant);
            end
            checks++;
            if ({dc_rsp_valid, ic_rsp_valid, pf_rsp_valid} !== e_rsp) begin
                failures++;
                $display("FAIL rnd_rsp cyc=%0d got %b%b%b want %b", cyc, dc_rsp_valid, ic_rsp_valid, pf_rsp_valid, e_rsp);
            end
            if (e_rsp != 3'b000) begin
                checks++;
                if (rsp_addr !== e_raddr || rsp_data !== mem2proc_data) begin
                    failures++;
                    $display("FAIL rnd_rsp_payload cyc=%0d got addr=%h data=%h want addr=%h data=%h",
                             cyc, rsp_addr, rsp_data, e_raddr, mem2proc_data);
                end
            end
            checks++;
            if (pf_outstanding !== 3'(pfo)) begin
                failures++;
                $display("FAIL rnd_pf_outstanding cyc=%0d got %0d want %0d", cyc, pf_outstanding, pfo);
            end

            if (mem2proc_tag != 0) m_valid[mem2proc_tag] = 0;
            if (pf_squash)
                for (int t = 1; t <= N; t++)
                    if (m_valid[t] && m_owner[t] == 2) m_drop[t] = 1;
            if (e_grant != 3'b000 && e_cmd == LOAD) begin
                m_valid[mem2proc_response] = 1;
                m_drop[mem2proc_response]  = 0;
                m_owner[mem2proc_response] = who - 1;
                m_addr[mem2proc_response]  = e_addr;
            end
            if (e_grant == 3'b010)   m_starve = 0;
            else if (ic_valid)       m_starve = (m_starve + 1 > LIM) ? LIM : m_starve + 1;
            dc_hold = (dc_cmd != NONE) && (e_grant != 3'b100);
            ic_hold = ic_valid && (e_grant != 3'b010);
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_dc_priority();
        test_starvation();
        test_pf_limit();
        test_squash();
        test_retry();
        test_same_tag();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
